// File: rtl/net_drive_pkg.sv
// Shared types and sizing helpers for the shared-net drive arbiter.
// Holds the FSM state encoding and the hold-counter width rule.
package net_drive_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2
   } drv_state_e;

   // Counter must represent HOLD_MAX itself so it can saturate there.
   function automatic int hold_cnt_width(input int hold_max);
      return (hold_max < 2) ? 1 : $clog2(hold_max + 1);
   endfunction

   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after the start pointer,
// wrapping around; combinational, one-hot result.
module rr_pick
   import net_drive_pkg::*;
#(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0]         req,
   input  logic [$clog2(N_CH)-1:0] start,
   output logic [N_CH-1:0]         pick,
   output logic                    valid
);

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      for (int off = 0; off < N_CH; off++) begin
         if (!valid && req[rr_wrap(int'(start) + off, N_CH)]) begin
            pick[rr_wrap(int'(start) + off, N_CH)] = 1'b1;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/net_drive_arb.sv
// Arbitrates ownership of a shared bidirectional net between N_CH channels,
// with a forced turnaround between owners and readback contention detection.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no owner, driver off; grants first requester on next edge
//   ST_DRIVE | owner set, driver on, hold counter running
//   ST_TURN  | one cycle with driver off before anyone may drive again
module net_drive_arb
   import net_drive_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int W        = 8,
   parameter int HOLD_MAX = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         req,
   input  logic [N_CH-1:0]         rel,
   input  logic [N_CH*W-1:0]       drv_data,
   input  logic [W-1:0]            net_in,
   output logic [N_CH-1:0]         gnt,
   output logic                    net_oe,
   output logic [W-1:0]            net_out,
   output logic                    contention,
   output logic                    err_sticky,
   input  logic                    err_clr,
   output logic [$clog2(N_CH)-1:0] err_ch
);

   localparam int IW = $clog2(N_CH);
   localparam int HW = hold_cnt_width(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_FIRST = HW'(1);

   drv_state_e      state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   ptr;
   logic [HW-1:0]   hold;
   logic [N_CH-1:0] pick;
   logic            pick_vld;
   logic [IW-1:0]   pick_idx;
   logic [IW-1:0]   next_ptr;
   logic [W-1:0]    slice [N_CH];
   logic            owner_done;
   logic            mismatch;

   for (genvar i = 0; i < N_CH; i++) begin : g_slice
      assign slice[i] = drv_data[i*W +: W];
   end

   rr_pick #(.N_CH(N_CH)) u_rr_pick (
      .req   (req),
      .start (ptr),
      .pick  (pick),
      .valid (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (pick[i]) pick_idx = IW'(i);
      end
   end

   assign next_ptr   = (pick_idx == IW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
   assign owner_done = rel[owner] | ~req[owner] | (hold == HOLD_LAST);
   // The first DRIVE cycle is skipped: net_out has only just been loaded.
   assign mismatch   = (state == ST_DRIVE) && (hold != HOLD_FIRST) && (net_in != net_out);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= '0;
         ptr        <= '0;
         hold       <= '0;
         gnt        <= '0;
         net_oe     <= 1'b0;
         net_out    <= '0;
         contention <= 1'b0;
         err_sticky <= 1'b0;
         err_ch     <= '0;
      end else begin
         contention <= mismatch;
         if (mismatch) begin
            err_sticky <= 1'b1;
            err_ch     <= owner;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state   <= ST_DRIVE;
                  owner   <= pick_idx;
                  ptr     <= next_ptr;
                  hold    <= HOLD_FIRST;
                  gnt     <= pick;
                  net_oe  <= 1'b1;
                  net_out <= slice[pick_idx];
               end else begin
                  net_out <= '0;
               end
            end
            ST_DRIVE: begin
               if (owner_done) begin
                  state   <= ST_TURN;
                  gnt     <= '0;
                  net_oe  <= 1'b0;
                  net_out <= '0;
               end else begin
                  net_out <= slice[owner];
                  if (hold != HOLD_LAST) hold <= hold + 1'b1;
               end
            end
            ST_TURN: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               gnt    <= '0;
               net_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_net_drive_arb.sv
// Bench for net_drive_arb: directed vector table, hand sequences for reset,
// then randomized traffic against a rule-level reference model.
module tb_net_drive_arb;

   localparam int N = 4;
   localparam int WD = 8;
   localparam int HM = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  rel = '0;
   logic [N*WD-1:0] drv_data = '0;
   logic [WD-1:0] net_in = '0;
   logic [N-1:0]  gnt;
   logic          net_oe;
   logic [WD-1:0] net_out;
   logic          contention;
   logic          err_sticky;
   logic          err_clr = 1'b0;
   logic [1:0]    err_ch;

   int checks = 0;
   int errors = 0;

   net_drive_arb #(.N_CH(N), .W(WD), .HOLD_MAX(HM)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .drv_data(drv_data),
      .net_in(net_in), .gnt(gnt), .net_oe(net_oe), .net_out(net_out),
      .contention(contention), .err_sticky(err_sticky), .err_clr(err_clr),
      .err_ch(err_ch)
   );

   always #5 clk = ~clk;

   // reference model state
   int          m_owner, m_cnt, m_ptr, m_ech;
   bit          m_turn, m_cont, m_stk;
   logic [WD-1:0] m_out;

   task automatic model_reset();
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_ech = 0;
      m_turn = 0; m_cont = 0; m_stk = 0; m_out = '0;
   endtask

   task automatic model_edge();
      bit mism;
      bit done;
      mism = (m_owner >= 0) && (m_cnt >= 2) && (net_in != m_out);
      m_cont = mism;
      if (mism) begin
         m_stk = 1;
         m_ech = m_owner;
      end else if (err_clr) begin
         m_stk = 0;
      end
      if (m_owner >= 0) begin
         done = rel[m_owner] || !req[m_owner] || (m_cnt == HM);
         if (done) begin
            m_owner = -1; m_turn = 1; m_out = '0;
         end else begin
            m_cnt++;
            m_out = drv_data[m_owner*WD +: WD];
         end
      end else if (m_turn) begin
         m_turn = 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         end
         if (m_owner >= 0) begin
            m_cnt = 1;
            m_ptr = (m_owner + 1) % N;
            m_out = drv_data[m_owner*WD +: WD];
         end else begin
            m_out = '0;
         end
      end
   endtask

   function automatic logic [N-1:0] m_gnt();
      return (m_owner >= 0) ? N'(1 << m_owner) : '0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] rl, input bit frc,
                        input logic [WD-1:0] fv, input bit clr);
      req = r; rel = rl; err_clr = clr;
      net_in = frc ? fv : m_out;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] rel;
      bit           frc;
      bit           clr;
      logic [N-1:0] e_gnt;
      bit           e_cont;
      bit           e_stk;
      logic [1:0]   e_ech;
   } vec_t;

   vec_t tbl [27];
   logic [N*WD-1:0] fixed_drv;

   function automatic logic [WD-1:0] slice_of(input logic [N-1:0] g);
      logic [WD-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) if (g[i]) s = fixed_drv[i*WD +: WD];
      return s;
   endfunction

   initial begin
      fixed_drv = {8'h5A, 8'hC2, 8'hB1, 8'hA0};
      tbl[0]  = '{4'b0110, 4'b0000, 0, 0, 4'b0010, 0, 0, 2'd0};
      tbl[1]  = '{4'b0110, 4'b0000, 0, 0, 4'b0010, 0, 0, 2'd0};
      tbl[2]  = '{4'b0110, 4'b0010, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[3]  = '{4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[4]  = '{4'b0100, 4'b0000, 0, 0, 4'b0100, 0, 0, 2'd0};
      tbl[5]  = '{4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[6]  = '{4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[7]  = '{4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 2'd0};
      tbl[8]  = '{4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 2'd0};
      tbl[9]  = '{4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 2'd0};
      tbl[10] = '{4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[11] = '{4'b0011, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[12] = '{4'b0011, 4'b0000, 0, 0, 4'b0010, 0, 0, 2'd0};
      tbl[13] = '{4'b0010, 4'b0010, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[14] = '{4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[15] = '{4'b0001, 4'b0000, 0, 0, 4'b0001, 0, 0, 2'd0};
      tbl[16] = '{4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[17] = '{4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'd0};
      tbl[18] = '{4'b1000, 4'b0000, 0, 0, 4'b1000, 0, 0, 2'd0};
      tbl[19] = '{4'b1000, 4'b0000, 1, 0, 4'b1000, 0, 0, 2'd0};
      tbl[20] = '{4'b1000, 4'b0000, 1, 0, 4'b1000, 1, 1, 2'd3};
      tbl[21] = '{4'b1000, 4'b0000, 0, 0, 4'b0000, 0, 1, 2'd3};
      tbl[22] = '{4'b1000, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd3};
      tbl[23] = '{4'b1000, 4'b0000, 0, 0, 4'b1000, 0, 0, 2'd3};
      tbl[24] = '{4'b1000, 4'b0000, 0, 0, 4'b1000, 0, 0, 2'd3};
      tbl[25] = '{4'b1000, 4'b0000, 1, 1, 4'b1000, 1, 1, 2'd3};
      tbl[26] = '{4'b1000, 4'b0000, 0, 1, 4'b0000, 0, 0, 2'd3};

      model_reset();
      drv_data = fixed_drv;
      #12;
      chk("rst_gnt", gnt, 0);
      chk("rst_oe", net_oe, 0);
      chk("rst_out", net_out, 0);
      chk("rst_cont", contention, 0);
      chk("rst_stk", err_sticky, 0);
      chk("rst_ech", err_ch, 0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].req, tbl[i].rel, tbl[i].frc, 8'hFF, tbl[i].clr);
         step();
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_oe", i), net_oe, |tbl[i].e_gnt);
         if (|tbl[i].e_gnt) chk($sformatf("tbl%0d_out", i), net_out, slice_of(tbl[i].e_gnt));
         chk($sformatf("tbl%0d_cont", i), contention, tbl[i].e_cont);
         chk($sformatf("tbl%0d_stk", i), err_sticky, tbl[i].e_stk);
         chk($sformatf("tbl%0d_ech", i), err_ch, tbl[i].e_ech);
      end

      // reset in the middle of a drive burst
      drive(4'b1110, 4'b0000, 0, 8'h00, 0);
      step();
      drive(4'b1110, 4'b0000, 0, 8'h00, 0);
      step();
      chk("mid_gnt_pre", gnt, 4'b0010);
      drive(4'b1110, 4'b0000, 0, 8'h00, 0);
      step();
      chk("mid_oe_pre", net_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_oe", net_oe, 0);
      chk("async_gnt", gnt, 0);
      chk("async_out", net_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(4'b1100, 4'b0000, 0, 8'h00, 0);
      step();
      chk("post_rst_gnt", gnt, 4'b0100);
      chk("post_rst_out", net_out, 8'hC2);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         logic [N-1:0] r;
         logic [N-1:0] rl;
         r  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : req;
         rl = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
         drv_data = N*WD'($urandom);
         drive(r, rl, $urandom_range(0, 9) == 0, WD'($urandom), $urandom_range(0, 5) == 0);
         step();
         chk("rnd_gnt", gnt, m_gnt());
         chk("rnd_oe", net_oe, m_owner >= 0);
         if (m_owner >= 0) chk("rnd_out", net_out, m_out);
         chk("rnd_cont", contention, m_cont);
         chk("rnd_stk", err_sticky, m_stk);
         chk("rnd_ech", err_ch, m_ech);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/net_drive_arb.md
NET_DRIVE_ARB -- requirements
Module: net_drive_arb

Interface
REQ-001 SHALL provide parameter N_CH, default 4, number of channels that may drive the shared net (2..16).
REQ-002 SHALL provide parameter W, default 8, shared net width in bits (1..64).
REQ-003 SHALL provide parameter HOLD_MAX, default 15, maximum consecutive DRIVE cycles per grant (1..255).
REQ-004 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL provide port req  input  N_CH  per-channel request to drive the net.
REQ-007 SHALL provide port rel  input  N_CH  per-channel voluntary release; only the owner's bit is honoured.
REQ-008 SHALL provide port drv_data  input  N_CH*W  per-channel drive value; channel i occupies bits [i*W +: W].
REQ-009 SHALL provide port net_in  input  W  readback of the resolved shared net.
REQ-010 SHALL provide port gnt  output  N_CH  one-hot grant; all zero when there is no owner.
REQ-011 SHALL provide port net_oe  output  1  output enable of the shared-net driver.
REQ-012 SHALL provide port net_out  output  W  registered value driven while net_oe is 1.
REQ-013 SHALL provide port contention  output  1  single-cycle pulse on readback mismatch.
REQ-014 SHALL provide port err_sticky  output  1  set by contention, cleared by err_clr.
REQ-015 SHALL provide port err_clr  input  1  synchronous clear of err_sticky.
REQ-016 SHALL provide port err_ch  output  $clog2(N_CH)  channel that owned the net at the most recent contention.

Function
REQ-017 SHALL implement a three-state FSM: IDLE (no owner, net_oe 0), DRIVE (owner set, net_oe 1), TURN (one turnaround cycle, net_oe 0).
REQ-018 IDLE->DRIVE SHALL occur on the first edge where req is non-zero; gnt, net_oe and net_out SHALL be valid one cycle after req is sampled.
REQ-019 Arbitration SHALL be round-robin, searching from (last owner + 1) mod N_CH; after reset the search SHALL start at channel 0.
REQ-020 In DRIVE, net_out SHALL register the owner's drv_data slice every cycle (one-cycle latency).
REQ-021 DRIVE->TURN SHALL occur when the owner's rel is 1, when the owner's req is 0, or when the hold counter reaches HOLD_MAX (forced release).
REQ-022 TURN SHALL last exactly one cycle with gnt all zero and then go to IDLE; a pending req in IDLE is then granted on the next edge, so owners are always separated by at least two cycles of net_oe 0.
REQ-023 The hold counter SHALL reset to 1 on entry to DRIVE, increment each DRIVE cycle, and saturate; it SHALL not wrap.
REQ-024 Contention SHALL be checked only from the second DRIVE cycle onward; net_in != net_out SHALL pulse contention for one cycle, set err_sticky and load err_ch with the owner index.
REQ-025 If err_clr and a new contention occur in the same cycle, err_sticky SHALL remain 1.
REQ-026 req bits of non-owners SHALL not affect the current owner; simultaneous requests in IDLE SHALL resolve in a single cycle.

Reset
REQ-027 With rst_n 0, outputs SHALL be forced immediately: state IDLE, gnt 0, net_oe 0, net_out 0, contention 0, err_sticky 0, err_ch 0, hold counter 0, round-robin pointer at channel 0.
REQ-028 Reset asserted during DRIVE SHALL drop net_oe asynchronously; after deassertion, operation SHALL restart from IDLE with no turnaround cycle owed.

Structure
REQ-029 The FSM state enumeration and the HOLD counter width rule SHALL live in the shared package net_drive_pkg.
REQ-030 The round-robin selector SHALL be a sub-module rr_pick (inputs: request vector and start pointer; outputs: one-hot pick and valid).

Verification
REQ-031 N_CH=4: req=4'b0110 from reset -> gnt=4'b0010 one cycle later, net_oe=1.
REQ-032 Owner ch1 asserts rel -> one TURN cycle with net_oe=0, then gnt=4'b0100 (ch2) while req[2] is still held.
REQ-033 HOLD_MAX=3, ch0 holds req continuously -> exactly 3 DRIVE cycles, then forced TURN; ch0 regranted only if no other channel is requesting.
REQ-034 Force net_in=8'hFF while net_out=8'h5A in the second DRIVE cycle of ch3 -> contention pulses once, err_sticky=1, err_ch=3.
REQ-035 err_clr pulsed together with a new mismatch -> err_sticky remains 1; err_clr alone -> err_sticky=0 on the next edge.
REQ-036 rst_n dropped mid-DRIVE -> net_oe=0 and gnt=0 before the next edge; first post-reset grant goes to the lowest requesting channel.
